// File: rtl/slicer_4ask.sv
`default_nettype none
// ============================================================================
//  Module   : slicer_4ask
//  Purpose  : Two-channel (I/Q) 4-ASK decision slicer with an adaptive
//             outer/inner decision threshold. The threshold is the mean |x|
//             over each block of 2^ACC_LOG2 symbols (both channels). For
//             levels +-a and +-3a this mean is 2a, the optimum boundary.
//  Config   : define SLICER_FIXED_REF_EN to drop the estimator and slice
//             permanently against FIXED_REF.
//  Revision : 1.0 - initial release
// ============================================================================
module slicer_4ask #(
   parameter int               WIDTH     = 18,
   parameter int               ACC_LOG2  = 10,
   parameter logic [WIDTH-1:0] FIXED_REF = 18'd32768
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    sym_clk_en,
   input  logic signed [WIDTH-1:0] in_I,
   input  logic signed [WIDTH-1:0] in_Q,
   output logic [1:0]              slicer_out_I,
   output logic [1:0]              slicer_out_Q,
   output logic                    sym_valid,
   output logic [WIDTH-2:0]        ref_level,
   output logic                    ref_valid
);

   localparam logic [WIDTH-2:0] c_fixed_ref = FIXED_REF[WIDTH-2:0];

   // Magnitude with the most negative code folded to the largest positive
   // value, so |x| always fits in WIDTH-1 unsigned bits.
   function automatic logic [WIDTH-2:0] f_mag(input logic signed [WIDTH-1:0] x);
      logic [WIDTH-1:0] neg;
      neg = WIDTH'(-x);
      if (!x[WIDTH-1])
         return x[WIDTH-2:0];
      else if (neg[WIDTH-1])
         return {(WIDTH-1){1'b1}};
      else
         return neg[WIDTH-2:0];
   endfunction

   // Code bit1 is the sign (1 = non-negative), bit0 selects outer vs inner;
   // for negatives the outer level is the lower code, hence the XOR.
   function automatic logic [1:0] f_dec(input logic             sgn,
                                        input logic [WIDTH-2:0] mag,
                                        input logic [WIDTH-2:0] thr);
      logic gt;
      gt = (mag > thr);
      return {~sgn, sgn ^ gt};
   endfunction

   logic [WIDTH-2:0] w_mag_i;
   logic [WIDTH-2:0] w_mag_q;
   logic [WIDTH-2:0] w_ref_level;

   assign w_mag_i = f_mag(in_I);
   assign w_mag_q = f_mag(in_Q);

   // Decision registers: slice against the threshold register as it stands
   // before this edge, hold between strobes.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         slicer_out_I <= 2'b10;
         slicer_out_Q <= 2'b10;
      end else if (sym_clk_en) begin
         slicer_out_I <= f_dec(in_I[WIDTH-1], w_mag_i, w_ref_level);
         slicer_out_Q <= f_dec(in_Q[WIDTH-1], w_mag_q, w_ref_level);
      end
   end

   // One-cycle decision strobe; back-to-back strobes keep it high.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset)
         sym_valid <= 1'b0;
      else
         sym_valid <= sym_clk_en;
   end

`ifdef SLICER_FIXED_REF_EN

   logic r_ref_valid;

   assign w_ref_level = c_fixed_ref;
   assign ref_level   = c_fixed_ref;
   assign ref_valid   = r_ref_valid;

   // The constant threshold is valid from the first edge after reset.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset)
         r_ref_valid <= 1'b0;
      else
         r_ref_valid <= 1'b1;
   end

`else

   localparam int ACC_W = WIDTH + ACC_LOG2;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } est_state_t;

   est_state_t          r_state;
   est_state_t          w_state_nxt;
   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_acc_sum;
   logic [ACC_LOG2-1:0] r_sym_cnt;
   logic [WIDTH-2:0]    r_ref_level;
   logic [WIDTH-2:0]    w_ref_new;
   logic                w_block_end;

   // Block sum of 2^(ACC_LOG2+1) magnitudes cannot exceed ACC_W bits, and
   // the mean is exactly the top WIDTH-1 bits of that sum.
   assign w_acc_sum   = r_acc + ACC_W'(w_mag_i) + ACC_W'(w_mag_q);
   assign w_ref_new   = w_acc_sum[ACC_W-1 -: WIDTH-1];
   assign w_block_end = sym_clk_en && (r_sym_cnt == {ACC_LOG2{1'b1}});

   assign w_ref_level = r_ref_level;
   assign ref_level   = r_ref_level;
   assign ref_valid   = (r_state == ST_TRACK);

   // Estimator state register.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset)
         r_state <= ST_INIT;
      else
         r_state <= w_state_nxt;
   end

   // INIT leaves at the first block end; TRACK is held until reset.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:  if (w_block_end) w_state_nxt = ST_TRACK;
         ST_TRACK: w_state_nxt = ST_TRACK;
         default:  w_state_nxt = ST_INIT;
      endcase
   end

   // Accumulate magnitudes per symbol; restart the sum at each block end.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_sym_cnt <= '0;
      end else if (sym_clk_en) begin
         r_sym_cnt <= r_sym_cnt + 1'b1;
         if (w_block_end)
            r_acc <= '0;
         else
            r_acc <= w_acc_sum;
      end
   end

   // Load the new mean at block end; first symbol of the next block uses it.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset)
         r_ref_level <= c_fixed_ref;
      else if (w_block_end)
         r_ref_level <= w_ref_new;
   end

`endif

endmodule
`default_nettype wire

// File: doc/slicer_4ask.md
# slicer_4ask

- Two-channel (I/Q) 4-ASK decision slicer with an adaptive decision threshold.
- Sits directly upstream of the BER tester:
  - Consumes the matched-filter output at symbol rate.
  - Produces the 2-bit slicer_out_I/slicer_out_Q codes that the BER tester serialises and compares against its LFSR.
- The threshold is a running estimate of mean |x|, recomputed once per block of 2^ACC_LOG2 symbols.
- For 4-ASK levels ±a and ±3a, mean |x| = 2a, which is exactly the optimum outer/inner boundary.

## Interface

Parameters:
- WIDTH, 18: input sample width, signed 1s17.
- ACC_LOG2, 10: log2 of symbols per threshold-estimation block.
- FIXED_REF, 18'd32768: reset/initial threshold; also the permanent threshold when SLICER_FIXED_REF_EN is defined.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- sym_clk_en  in  1  one-cycle symbol strobe; in_I/in_Q are sampled only when high.
- in_I  in  WIDTH  signed I sample from the matched filter.
- in_Q  in  WIDTH  signed Q sample from the matched filter.
- slicer_out_I  out  2  I decision code: 00=-3, 01=-1, 10=+1, 11=+3.
- slicer_out_Q  out  2  Q decision code, same encoding.
- sym_valid  out  1  one-cycle pulse marking new decisions.
- ref_level  out  WIDTH-1  unsigned threshold currently in use.
- ref_valid  out  1  sticky high once the first adaptive estimate has loaded.

## Operation

- Magnitude:
  - |x| = -x for negative x, else x.
  - The most negative code (-2^(WIDTH-1)) saturates to 2^(WIDTH-1)-1.
- Decision, per channel:
  - x >= 0 and |x| > ref_level → 11.
  - x >= 0 and |x| <= ref_level → 10.
  - x < 0 and |x| > ref_level → 00.
  - x < 0 and |x| <= ref_level → 01.
  - x = 0 decodes as 10.
  - |x| = ref_level decodes as the inner symbol.
- Decisions use the ref_level register value present at the sampling edge, not a value being loaded on that same edge.
- Estimator state:
  - Unsigned accumulator acc of WIDTH+ACC_LOG2 bits.
  - Symbol counter sym_cnt of ACC_LOG2 bits.
- On each sym_clk_en:
  - Add |I| + |Q| to acc.
  - Increment sym_cnt, wrapping to 0.
- Block end (sym_clk_en with sym_cnt = 2^ACC_LOG2-1):
  - ref_level <= (acc + |I| + |Q|) >> (ACC_LOG2+1), i.e. mean over 2·2^ACC_LOG2 magnitudes.
  - acc <= 0.
  - ref_valid <= 1.
- Accumulator cannot overflow: the maximum sum is 2^(ACC_LOG2+1)·(2^(WIDTH-1)-1) < 2^(WIDTH+ACC_LOG2).
- Estimator states:
  - INIT: ref_valid=0; FIXED_REF in use.
  - TRACK: ref_valid=1; estimate in use.
  - INIT→TRACK happens at the first block end. There is no transition back except through reset.
- Reset values:
  - slicer_out_I/Q = 2'b10.
  - sym_valid = 0.
  - ref_level = FIXED_REF.
  - ref_valid = 0.
  - acc = 0.
  - sym_cnt = 0.
- Reset asserted mid-block discards the partial accumulation. The next block starts fresh at sym_cnt=0.

## Timing

- Latency is 1 sys_clk:
  - Inputs are sampled on the edge where sym_clk_en=1.
  - slicer_out_I/Q and sym_valid=1 are visible right after that edge.
  - sym_valid drops on the next edge unless sym_clk_en is still high.
- slicer_out_I/Q hold their value between strobes.
- sym_clk_en may be high on every cycle. Each such cycle is a new symbol.
- At block end, the new ref_level and ref_valid become visible after the same edge that produced the last decision of the block.
  - That last decision uses the old threshold.
  - The first symbol of the next block uses the new threshold.
- There are no combinational paths from inputs to outputs.

## Configuration

- SLICER_FIXED_REF_EN defined:
  - Accumulator and counter are not compiled.
  - ref_level is the constant FIXED_REF.
  - ref_valid ties to 1 once reset is released.
- SLICER_FIXED_REF_EN undefined: adaptive estimator as described above. This is the default.

## Test plan

Defaults WIDTH=18, FIXED_REF=32768 unless stated.

- Reset then single strobes before any block end:
  - I = +16384, +49152, -49152, -16384 → slicer_out_I = 10, 11, 00, 01.
  - I = 0 → 10.
  - I = +32768 → 10 (equal to threshold).
  - sym_valid pulses exactly 1 cycle after each strobe.
- Saturation: I = -131072 → |I| = 131071 feeds acc; decision = 00.
- ACC_LOG2=4, 16 strobes with I=+40000, Q=-40000:
  - After the 16th strobe: ref_level = 40000 and ref_valid = 1.
  - The 16th decision still uses 32768.
  - The 17th strobe with I=+39999 → 10; I=+40001 → 11.
- ACC_LOG2=4, sym_clk_en high every cycle for 48 cycles with constant inputs:
  - ref_level updates exactly at cycles 16, 32, 48.
  - There are no missed or duplicated symbols.
- Reset after 10 strobes of a block:
  - Outputs return to their reset values.
  - The next block end occurs 16 strobes after reset release, not 6.
- With SLICER_FIXED_REF_EN defined:
  - 64 strobes of I=+60000 → ref_level stays 32768.
  - ref_valid = 1.
  - All decisions = 11.
